// File: rtl/mul8u_pkg.sv
// Shared widths, state encoding and width helpers for the mul8u error monitor.
package mul8u_pkg;

    localparam int OPW   = 8;
    localparam int PRODW = 16;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2
    } mon_state_e;

    function automatic int SUMW(input int win_log2);
        return PRODW + win_log2;
    endfunction

    function automatic int CNTW(input int win_log2);
        return win_log2 + 1;
    endfunction

endpackage

// File: rtl/mul8u_err_calc.sv
// Stages 1 and 2 of the error monitor: exact product, absolute error and, with
// ERR_MON_SQ_EN defined, the squared error; carries a two-deep valid pipeline.
module mul8u_err_calc
    import mul8u_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [OPW-1:0]   i_a,
    input  logic [OPW-1:0]   i_b,
    input  logic [PRODW-1:0] i_o,
    output logic             o_s1_valid,
    output logic             o_s2_valid,
    output logic [OPW-1:0]   o_a,
    output logic [OPW-1:0]   o_b,
    output logic [PRODW-1:0] o_abs_err
`ifdef ERR_MON_SQ_EN
    ,
    output logic [2*PRODW-1:0] o_sq_err
`endif
);

    logic             r_s1_valid;
    logic             r_s2_valid;
    logic [OPW-1:0]   r_a1;
    logic [OPW-1:0]   r_b1;
    logic [PRODW-1:0] r_o1;
    logic [PRODW-1:0] r_exact1;
    logic [OPW-1:0]   r_a2;
    logic [OPW-1:0]   r_b2;
    logic [PRODW-1:0] r_abs2;
    logic [PRODW-1:0] w_abs_err;

    // 255*255 fits in PRODW, so the exact product never wraps.
    always_comb begin
        w_abs_err = (r_exact1 >= r_o1) ? (r_exact1 - r_o1) : (r_o1 - r_exact1);
    end

    // NOTE: flops are written with non-blocking assignments so each one samples
    // the pre-edge value of its source independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (i_flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a1     <= '0;
            r_b1     <= '0;
            r_o1     <= '0;
            r_exact1 <= '0;
            r_a2     <= '0;
            r_b2     <= '0;
            r_abs2   <= '0;
        end else begin
            if (i_valid) begin
                r_a1     <= i_a;
                r_b1     <= i_b;
                r_o1     <= i_o;
                r_exact1 <= PRODW'(i_a) * PRODW'(i_b);
            end
            if (r_s1_valid) begin
                r_a2   <= r_a1;
                r_b2   <= r_b1;
                r_abs2 <= w_abs_err;
            end
        end
    end

`ifdef ERR_MON_SQ_EN
    logic [2*PRODW-1:0] r_sq2;

    // Squaring the magnitude gives the same result as squaring the signed difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq2 <= '0;
        end else if (r_s1_valid) begin
            r_sq2 <= (2*PRODW)'(w_abs_err) * (2*PRODW)'(w_abs_err);
        end
    end

    assign o_sq_err = r_sq2;
`endif

    assign o_s1_valid = r_s1_valid;
    assign o_s2_valid = r_s2_valid;
    assign o_a        = r_a2;
    assign o_b        = r_b2;
    assign o_abs_err  = r_abs2;

endmodule

// File: rtl/mul8u_err_monitor.sv
// Windowed error statistics for the mul8u approximate multiplier; defining
// ERR_MON_SQ_EN adds the sum-of-squared-error accumulator and sum_sq_err port.
module mul8u_err_monitor
    import mul8u_pkg::*;
#(
    parameter int WIN_LOG2 = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OPW-1:0]                in_a,
    input  logic [OPW-1:0]                in_b,
    input  logic [PRODW-1:0]              in_o,
    output logic                          stat_valid,
    input  logic                          stat_ready,
    output logic [SUMW(WIN_LOG2)-1:0]     sum_abs_err,
    output logic [PRODW-1:0]              max_abs_err,
    output logic [OPW-1:0]                max_a,
    output logic [OPW-1:0]                max_b,
    output logic [CNTW(WIN_LOG2)-1:0]     err_count
`ifdef ERR_MON_SQ_EN
    ,
    output logic [2*PRODW+WIN_LOG2-1:0]   sum_sq_err
`endif
);

    localparam int SW = SUMW(WIN_LOG2);
    localparam int CW = CNTW(WIN_LOG2);
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << WIN_LOG2) - 1);

    mon_state_e       r_state;
    mon_state_e       w_state_nxt;
    logic             r_live;
    logic [CW-1:0]    r_acc_cnt;
    logic [CW-1:0]    r_err_cnt;
    logic [SW-1:0]    r_sum;
    logic [PRODW-1:0] r_max;
    logic [OPW-1:0]   r_max_a;
    logic [OPW-1:0]   r_max_b;
    logic             w_accept;
    logic             w_stat_hs;
    logic             w_s1_valid;
    logic             w_s2_valid;
    logic [OPW-1:0]   w_a;
    logic [OPW-1:0]   w_b;
    logic [PRODW-1:0] w_abs_err;

    assign w_accept  = in_valid && in_ready;
    assign w_stat_hs = stat_valid && stat_ready;

`ifdef ERR_MON_SQ_EN
    logic [2*PRODW-1:0]          w_sq_err;
    logic [2*PRODW+WIN_LOG2-1:0] r_sum_sq;
`endif

    mul8u_err_calc u_calc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (clr),
        .i_valid    (w_accept),
        .i_a        (in_a),
        .i_b        (in_b),
        .i_o        (in_o),
        .o_s1_valid (w_s1_valid),
        .o_s2_valid (w_s2_valid),
        .o_a        (w_a),
        .o_b        (w_b),
        .o_abs_err  (w_abs_err)
`ifdef ERR_MON_SQ_EN
        ,
        .o_sq_err   (w_sq_err)
`endif
    );

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_live <= 1'b0;
        else        r_live <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACCUM;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_accept && (r_acc_cnt == LAST_IDX)) w_state_nxt = DRAIN;
            DRAIN:   if (!w_s1_valid && !w_s2_valid)         w_state_nxt = REPORT;
            REPORT:  if (stat_ready)                         w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
        if (clr) w_state_nxt = ACCUM;
    end

    always_comb begin
        in_ready   = r_live && (r_state == ACCUM);
        stat_valid = (r_state == REPORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
        end else if (clr || w_stat_hs) begin
            r_acc_cnt <= '0;
        end else if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + CW'(1);
        end
    end

    // Strict > keeps the earliest sample on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_err_cnt <= '0;
            r_max     <= '0;
            r_max_a   <= '0;
            r_max_b   <= '0;
        end else if (clr || w_stat_hs) begin
            r_sum     <= '0;
            r_err_cnt <= '0;
            r_max     <= '0;
            r_max_a   <= '0;
            r_max_b   <= '0;
        end else if (w_s2_valid) begin
            r_sum <= r_sum + SW'(w_abs_err);
            if (w_abs_err != '0) r_err_cnt <= r_err_cnt + CW'(1);
            if (w_abs_err > r_max) begin
                r_max   <= w_abs_err;
                r_max_a <= w_a;
                r_max_b <= w_b;
            end
        end
    end

`ifdef ERR_MON_SQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_sq <= '0;
        end else if (clr || w_stat_hs) begin
            r_sum_sq <= '0;
        end else if (w_s2_valid) begin
            r_sum_sq <= r_sum_sq + (2*PRODW+WIN_LOG2)'(w_sq_err);
        end
    end

    assign sum_sq_err = r_sum_sq;
`endif

    assign sum_abs_err = r_sum;
    assign max_abs_err = r_max;
    assign max_a       = r_max_a;
    assign max_b       = r_max_b;
    assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_mul8u_err_monitor.sv
// Bench for mul8u_err_monitor: table vectors and corner sequences on a 4-sample
// window, random windows against a reference model, and a 16-sample window.
module tb_mul8u_err_monitor;

    localparam int W   = 2;
    localparam int W16 = 4;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] o;
    } smp_t;

    typedef struct packed {
        logic [17:0] sum;
        logic [15:0] mx;
        logic [7:0]  ma;
        logic [7:0]  mb;
        logic [2:0]  cnt;
        logic [33:0] sq;
    } stat_t;

    typedef struct packed {
        smp_t [0:3] s;
        stat_t      e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        stat_ready = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [15:0] in_o = '0;
    logic        in_ready;
    logic        stat_valid;
    logic [17:0] sum_abs_err;
    logic [15:0] max_abs_err;
    logic [7:0]  max_a;
    logic [7:0]  max_b;
    logic [2:0]  err_count;

    logic        v16 = 1'b0;
    logic        sr16 = 1'b0;
    logic [7:0]  a16 = '0;
    logic [7:0]  b16 = '0;
    logic [15:0] o16 = '0;
    logic        rdy16;
    logic        sv16;
    logic [19:0] sum16;
    logic [15:0] max16;
    logic [7:0]  ma16;
    logic [7:0]  mb16;
    logic [4:0]  cnt16;

`ifdef ERR_MON_SQ_EN
    logic [33:0] sum_sq_err;
    logic [35:0] sq16;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc = 0;

    mul8u_err_monitor #(.WIN_LOG2(W)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_o        (in_o),
        .stat_valid  (stat_valid),
        .stat_ready  (stat_ready),
        .sum_abs_err (sum_abs_err),
        .max_abs_err (max_abs_err),
        .max_a       (max_a),
        .max_b       (max_b),
        .err_count   (err_count)
`ifdef ERR_MON_SQ_EN
        ,
        .sum_sq_err  (sum_sq_err)
`endif
    );

    mul8u_err_monitor #(.WIN_LOG2(W16)) u_dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (v16),
        .in_ready    (rdy16),
        .in_a        (a16),
        .in_b        (b16),
        .in_o        (o16),
        .stat_valid  (sv16),
        .stat_ready  (sr16),
        .sum_abs_err (sum16),
        .max_abs_err (max16),
        .max_a       (ma16),
        .max_b       (mb16),
        .err_count   (cnt16)
`ifdef ERR_MON_SQ_EN
        ,
        .sum_sq_err  (sq16)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic smp_t mk(input int a, input int b, input int o);
        smp_t s;
        s.a = 8'(a);
        s.b = 8'(b);
        s.o = 16'(o);
        return s;
    endfunction

    function automatic stat_t mkst(input longint sum, input int mx, input int ma,
                                   input int mb, input int cnt, input longint sq);
        stat_t s;
        s.sum = 18'(sum);
        s.mx  = 16'(mx);
        s.ma  = 8'(ma);
        s.mb  = 8'(mb);
        s.cnt = 3'(cnt);
        s.sq  = 34'(sq);
        return s;
    endfunction

    // Reference: window statistics straight from the arithmetic definitions.
    function automatic stat_t model(input smp_t [0:3] w);
        longint sum = 0;
        longint sq = 0;
        int mx = 0;
        int ma = 0;
        int mb = 0;
        int cnt = 0;
        for (int i = 0; i < 4; i++) begin
            int d;
            int ad;
            d  = int'(w[i].a) * int'(w[i].b) - int'(w[i].o);
            ad = (d < 0) ? -d : d;
            sum += longint'(ad);
            sq  += longint'(d) * longint'(d);
            if (d != 0) cnt++;
            if (ad > mx) begin
                mx = ad;
                ma = int'(w[i].a);
                mb = int'(w[i].b);
            end
        end
        return mkst(sum, mx, ma, mb, cnt, sq);
    endfunction

    function automatic smp_t rnd_smp();
        smp_t s;
        logic [15:0] exact;
        s.a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        s.b = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        exact = 16'(s.a) * 16'(s.b);
        case ($urandom_range(0, 3))
            0:       s.o = exact;
            1:       s.o = exact ^ (16'd1 << $urandom_range(0, 15));
            2:       s.o = 16'($urandom);
            default: s.o = exact + 16'($urandom_range(1, 9));
        endcase
        return s;
    endfunction

    task automatic check_stats(input string tag, input stat_t e);
        check({tag, "_sum"}, 64'(sum_abs_err), 64'(e.sum));
        check({tag, "_max"}, 64'(max_abs_err), 64'(e.mx));
        check({tag, "_max_a"}, 64'(max_a), 64'(e.ma));
        check({tag, "_max_b"}, 64'(max_b), 64'(e.mb));
        check({tag, "_err_count"}, 64'(err_count), 64'(e.cnt));
`ifdef ERR_MON_SQ_EN
        check({tag, "_sum_sq"}, 64'(sum_sq_err), 64'(e.sq));
`endif
    endtask

    // Offers one sample (after optional idle cycles) and returns just after its accept edge.
    task automatic push(input smp_t s, input int gap);
        int g;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_a = s.a;
        in_b = s.b;
        in_o = s.o;
        g = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            g++;
            if (g > 40) begin
                check("push_in_ready", 64'(in_ready), 64'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_report(output int lat);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (stat_valid) begin
                lat = cyc - last_acc;
                break;
            end
        end
    endtask

    task automatic handshake(input int hold, input stat_t e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_in_ready", 64'(in_ready), 64'(0));
            check("hold_stats",
                  64'({stat_valid, sum_abs_err, max_abs_err, max_a, max_b, err_count}),
                  64'({1'b1, e.sum, e.mx, e.ma, e.mb, e.cnt}));
        end
        @(posedge clk);
        #1;
        stat_ready = 1'b1;
        @(posedge clk);
        #1;
        stat_ready = 1'b0;
        @(negedge clk);
        check("post_hs_in_ready", 64'(in_ready), 64'(1));
        check("post_hs_stat_valid", 64'(stat_valid), 64'(0));
        check_stats("post_hs", mkst(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       vecs[5];
        stat_t      zero;
        stat_t      e;
        smp_t [0:3] w;
        int         lat;
        int         acc16;
        int         last16;
        int         guard;

        zero = mkst(0, 0, 0, 0, 0, 0);
        vecs[0] = {mk(255, 255, 64507), mk(3, 4, 12), mk(10, 10, 100), mk(0, 0, 0),
                   mkst(518, 518, 255, 255, 1, 268324)};
        vecs[1] = {mk(10, 10, 105), mk(20, 3, 51), mk(7, 7, 58), mk(2, 2, 1),
                   mkst(26, 9, 20, 3, 4, 196)};
        vecs[2] = {mk(1, 1, 1), mk(200, 100, 20000), mk(255, 0, 0), mk(17, 17, 289),
                   mkst(0, 0, 0, 0, 0, 0)};
        vecs[3] = {mk(0, 5, 65535), mk(255, 255, 65535), mk(1, 2, 0), mk(16, 16, 256),
                   mkst(66047, 65535, 0, 5, 3, 64'd4295096329)};
        vecs[4] = {mk(3, 3, 0), mk(9, 1, 0), mk(1, 1, 0), mk(0, 0, 0),
                   mkst(19, 9, 3, 3, 3, 163)};

        // Reset state and release timing.
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_stat_valid", 64'(stat_valid), 64'(0));
        check_stats("rst", zero);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_before_edge", 64'(in_ready), 64'(0));
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'(1));
        check("rel16_in_ready", 64'(rdy16), 64'(1));
        @(posedge clk);
        #1;

        // Table vectors; vector 1 also holds the report for 20 cycles.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) push(vecs[v].s[i], 0);
            wait_report(lat);
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'(3));
            check_stats($sformatf("vec%0d", v), vecs[v].e);
            handshake((v == 1) ? 20 : 0, vecs[v].e);
        end

        // clr coincident with the third accept drops the window and that sample.
        push(mk(10, 10, 0), 0);
        push(mk(5, 5, 0), 0);
        in_valid = 1'b1;
        in_a = 8'd7;
        in_b = 8'd7;
        in_o = 16'd0;
        clr = 1'b1;
        @(negedge clk);
        check("clr_accept_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_flushed_sum", 64'(sum_abs_err), 64'(0));
        check("clr_flushed_cnt", 64'(err_count), 64'(0));
        @(posedge clk);
        #1;
        w = {mk(2, 3, 0), mk(4, 4, 20), mk(9, 9, 81), mk(100, 2, 199)};
        for (int i = 0; i < 3; i++) push(w[i], 0);
        repeat (6) @(negedge clk);
        check("clr_no_early_report", 64'({stat_valid, in_ready}), 64'({1'b0, 1'b1}));
        @(posedge clk);
        #1;
        push(w[3], 0);
        wait_report(lat);
        check("clr_window_latency", 64'(lat), 64'(3));
        check_stats("clr_window", model(w));
        handshake(0, model(w));

        // Reset while draining loses the partial window.
        w = {mk(255, 255, 0), mk(1, 1, 0), mk(2, 2, 0), mk(3, 3, 0)};
        for (int i = 0; i < 4; i++) push(w[i], 0);
        rst_n = 1'b0;
        #1;
        check("drain_rst_stat_valid", 64'(stat_valid), 64'(0));
        check("drain_rst_in_ready", 64'(in_ready), 64'(0));
        check_stats("drain_rst", zero);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("drain_rel_before_edge", 64'(in_ready), 64'(0));
        @(negedge clk);
        check("drain_rel_in_ready", 64'(in_ready), 64'(1));
        repeat (6) @(negedge clk);
        check("drain_rst_no_report", 64'(stat_valid), 64'(0));
        check_stats("drain_rst_idle", zero);
        @(posedge clk);
        #1;

        // Random windows with input gaps and report back-pressure.
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 4; i++) w[i] = rnd_smp();
            e = model(w);
            for (int i = 0; i < 4; i++) push(w[i], $urandom_range(0, 2));
            wait_report(lat);
            check($sformatf("rnd%0d_latency", k), 64'(lat), 64'(3));
            check_stats($sformatf("rnd%0d", k), e);
            handshake($urandom_range(0, 3), e);
        end

        // 16-sample window, exact products, 50% in_valid duty.
        acc16 = 0;
        last16 = 0;
        guard = 0;
        while (acc16 < 16 && guard < 400) begin
            guard++;
            v16 = ($urandom_range(0, 1) == 1);
            a16 = 8'($urandom);
            b16 = 8'($urandom);
            o16 = 16'(a16) * 16'(b16);
            @(negedge clk);
            if (v16 && rdy16) begin
                acc16++;
                last16 = cyc + 1;
            end
            @(posedge clk);
            #1;
        end
        v16 = 1'b0;
        check("w16_accepts", 64'(acc16), 64'(16));
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sv16) begin
                lat = cyc - last16;
                break;
            end
        end
        check("w16_latency", 64'(lat), 64'(3));
        check("w16_in_ready_in_report", 64'(rdy16), 64'(0));
        check("w16_sum", 64'(sum16), 64'(0));
        check("w16_max", 64'({max16, ma16, mb16}), 64'(0));
        check("w16_err_count", 64'(cnt16), 64'(0));
`ifdef ERR_MON_SQ_EN
        check("w16_sum_sq", 64'(sq16), 64'(0));
`endif
        @(posedge clk);
        #1;
        sr16 = 1'b1;
        @(posedge clk);
        #1;
        sr16 = 1'b0;
        @(negedge clk);
        check("w16_post_hs", 64'({rdy16, sv16}), 64'({1'b1, 1'b0}));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mul8u_err_monitor.md
# mul8u_err_monitor

Streaming error-statistics stage placed directly downstream of the 8×8 unsigned approximate multiplier `mul8u`. It consumes each operand pair together with the approximate product, computes the exact product internally, and accumulates per-window error metrics over 2^WIN_LOG2 samples: sum of absolute error, worst-case error with its operands, and erroneous-sample count. It then presents the result on a valid/ready report port, which lets MAE, WCE and EP figures be checked in silicon or in simulation.

## Interface
- WIN_LOG2, default 10: window length is 2^WIN_LOG2 samples; legal range 1..16.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort: discards the current window and any pending report.
- in_valid  in  1  sample present.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_a  in  8  operand A as fed to mul8u.
- in_b  in  8  operand B as fed to mul8u.
- in_o  in  16  approximate product returned by mul8u.
- stat_valid  out  1  report available.
- stat_ready  in  1  report consumed when stat_valid && stat_ready.
- sum_abs_err  out  16+WIN_LOG2  Σ|A·B − O| over the window.
- max_abs_err  out  16  largest |A·B − O| in the window.
- max_a  out  8  A of the first sample reaching max_abs_err.
- max_b  out  8  B of the first sample reaching max_abs_err.
- err_count  out  WIN_LOG2+1  samples with O ≠ A·B.
- sum_sq_err  out  32+WIN_LOG2  Σ(A·B − O)²; present only with ERR_MON_SQ_EN.

## Operation
- States: ACCUM, DRAIN, REPORT.
- ACCUM: in_ready = 1 while accepted count < 2^WIN_LOG2. On the accept that reaches 2^WIN_LOG2, go to DRAIN.
- Pipeline stage 1 registers A, B, O and exact = A·B (16 bits).
- Pipeline stage 2 computes abs_err = exact ≥ O ? exact − O : O − exact, 16 bits unsigned, then updates the accumulators.
- Max update uses a strict >. Ties keep the earliest sample. With all-zero errors, max_a/max_b stay 0.
- DRAIN: in_ready = 0. Once both pipeline stages are empty, go to REPORT.
- REPORT: stat_valid = 1 and all stat outputs are held stable. On the stat_ready handshake: accumulators, counters and max fields clear to 0, and the state returns to ACCUM.
- Accumulator widths are sized so they never overflow. No saturation logic is used.
- clr: state returns to ACCUM, and pipeline valids, counters and accumulators go to 0 on the next edge. clr has priority over a simultaneous input accept (the sample is dropped) and over a simultaneous stat handshake.
- Out-of-range O (for example, above 65025) is not an error condition. It is processed arithmetically like any other value.

## Timing
- Reset values: in_ready = 0 while rst_n is low and 1 from the first edge after release. stat_valid = 0. All stat outputs are 0. State is ACCUM.
- Accept to accumulator update: 2 cycles.
- Final accept to stat_valid rising: 3 cycles (1 to DRAIN; DRAIN lasts until stage 2 retires; REPORT is registered).
- Report handshake to in_ready high: 1 cycle.
- Back-pressure on stat_ready is unbounded. in_ready stays 0 for the whole REPORT state.
- Reset asserted mid-window or mid-report: everything clears immediately and the partial window is lost.

## Configuration
- ERR_MON_SQ_EN defined: adds a 16×16 square of the signed difference in stage 2 and the sum_sq_err output port. Latency is unchanged.
- ERR_MON_SQ_EN undefined: no sum_sq_err port and no squarer logic. All other behaviour is identical.

## Structure
- Shared package `mul8u_pkg` holds:
  - OPW = 8 and PRODW = 16;
  - the state enum {ACCUM, DRAIN, REPORT};
  - the width helpers SUMW(WIN_LOG2) = 16 + WIN_LOG2 and CNTW(WIN_LOG2) = WIN_LOG2 + 1.
- One sub-module, `mul8u_err_calc`: stages 1 and 2 (exact product, absolute error, optional square, valid pipeline).
- The top level holds the FSM, counters and accumulators.

## Test plan
- WIN_LOG2=2; four samples (255,255,O=64507) and three with exact O -> sum_abs_err=518, max_abs_err=518, max_a=255, max_b=255, err_count=1.
- WIN_LOG2=2; errors 5,9,9,3 -> max_abs_err=9 with the operands of the second sample, sum=26, err_count=4; with ERR_MON_SQ_EN, sum_sq_err=25+81+81+9=196.
- Hold stat_ready=0 for 20 cycles in REPORT -> stat outputs stable and in_ready=0 throughout; in_ready=1 one cycle after the handshake, with all stats reading 0.
- Assert clr on the same cycle as the 3rd accept -> stat_valid never rises, and the next window of 4 reports only post-clr samples.
- Assert rst_n low while in DRAIN -> stat_valid=0, all outputs 0, in_ready=1 from the first edge after release.
- Random in_valid gaps (50% duty), WIN_LOG2=4, O = exact product -> err_count=0, sum=0, max=0, and stat_valid rises exactly 3 cycles after the 16th accept.
